// File: rtl/bsg_bp_mc_link_sched_pkg.sv
// Shared definitions for the manycore request-link scheduler: FSM state
// encoding, default parameter values and a width helper.
package bsg_bp_mc_link_sched_pkg;

    localparam int unsigned num_req_default_lp         = 4;
    localparam int unsigned packet_width_default_lp    = 128;
    localparam int unsigned max_out_credits_default_lp = 16;

    typedef enum logic [1:0] {
        eReady = 2'd0,
        eHold  = 2'd1,
        eFence = 2'd2
    } state_e;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_bp_mc_rr_select.sv
// Round-robin selector: scans the request vector starting at ptr_i and
// wrapping, returning the first valid requester as one-hot and as an index.
module bsg_bp_mc_rr_select
    import bsg_bp_mc_link_sched_pkg::*;
#(
    parameter int unsigned num_req_p   = num_req_default_lp,
    parameter int unsigned idx_width_p = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   req_i,
    input  logic [idx_width_p-1:0] ptr_i,
    output logic [num_req_p-1:0]   grant_o,
    output logic [idx_width_p-1:0] idx_o,
    output logic                   v_o
);

    int unsigned            cand_full;
    logic [idx_width_p-1:0] cand;

    // First valid requester at or after the pointer wins.
    always_comb begin
        grant_o   = '0;
        idx_o     = '0;
        v_o       = 1'b0;
        cand_full = 0;
        cand      = '0;
        for (int unsigned off = 0; off < num_req_p; off++) begin
            cand_full = (32'(ptr_i) + off) % num_req_p;
            cand      = idx_width_p'(cand_full);
            if (!v_o && req_i[cand]) begin
                v_o           = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/bsg_bp_mc_link_scheduler.sv
// Arbitrates num_req_p requesters onto one credit-controlled manycore request
// link through a single-entry output buffer, with fence/drain support.
// Optional statistics counters are built when BSG_BP_MC_LINK_SCHED_STATS_EN
// is defined.
// Handshake: a transfer happens on a cycle where valid and ready are both
// high; valid never waits on ready, and data/id hold while valid & !ready.
module bsg_bp_mc_link_scheduler
    import bsg_bp_mc_link_sched_pkg::*;
#(
    parameter int unsigned  num_req_p         = num_req_default_lp,
    parameter int unsigned  packet_width_p    = packet_width_default_lp,
    parameter int unsigned  max_out_credits_p = max_out_credits_default_lp,
    localparam int unsigned id_width_lp       = safe_clog2(num_req_p),
    localparam int unsigned credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    input  logic [num_req_p-1:0][packet_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                     req_ready_o,
    output logic                                     pkt_v_o,
    output logic [packet_width_p-1:0]                pkt_data_o,
    input  logic                                     pkt_ready_i,
    output logic [id_width_lp-1:0]                   grant_id_o,
    input  logic                                     credit_return_i,
    output logic [credit_width_lp-1:0]               credits_o,
    input  logic                                     fence_i,
    output logic                                     fence_done_o,
    output logic                                     credit_err_o,
    output state_e                                   state_o
`ifdef BSG_BP_MC_LINK_SCHED_STATS_EN
    ,
    output logic [31:0]                              issued_count_o,
    output logic [31:0]                              stall_cycles_o
`endif
);

    localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(max_out_credits_p);

    state_e                      state_q, state_d;
    logic                        pkt_v_q, pkt_v_d;
    logic [packet_width_p-1:0]   pkt_data_q, pkt_data_d;
    logic [id_width_lp-1:0]      grant_id_q, grant_id_d;
    logic [id_width_lp-1:0]      rr_ptr_q, rr_ptr_d;
    logic [credit_width_lp-1:0]  credits_q, credits_d;
    logic                        fence_active_q, fence_active_d;
    logic                        fence_done_q, fence_done_d;
    logic                        credit_err_q, credit_err_d;

    logic [num_req_p-1:0]        rr_grant;
    logic [id_width_lp-1:0]      rr_idx;
    logic                        rr_v;
    logic                        out_fire;
    logic                        accept_slot;
    logic                        accept;

    bsg_bp_mc_rr_select #(
        .num_req_p   (num_req_p),
        .idx_width_p (id_width_lp)
    ) rr_select (
        .req_i   (req_v_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .v_o     (rr_v)
    );

    // Offer a slot when the buffer is empty or emptying, credits remain and no fence blocks.
    always_comb begin
        out_fire    = pkt_v_q & pkt_ready_i;
        accept_slot = reset_n_i
                    && ((state_q == eReady) || ((state_q == eHold) && out_fire))
                    && (credits_q != '0)
                    && !fence_active_q;
        accept      = accept_slot & rr_v;
        req_ready_o = accept_slot ? rr_grant : '0;
    end

    // Next-state: credits, buffer load, RR pointer, fence tracking and FSM.
    always_comb begin
        state_d        = state_q;
        pkt_v_d        = pkt_v_q;
        pkt_data_d     = pkt_data_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        credits_d      = credits_q;
        fence_active_d = fence_active_q;
        fence_done_d   = 1'b0;
        credit_err_d   = credit_err_q;

        // A return that coincides with an acceptance cancels out; a return
        // into a full pool is dropped and flagged.
        if (accept && !credit_return_i) begin
            credits_d = credits_q - credit_width_lp'(1);
        end else if (!accept && credit_return_i) begin
            if (credits_q == credits_max_lp) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + credit_width_lp'(1);
            end
        end

        if (accept) begin
            pkt_data_d = req_data_i[rr_idx];
            grant_id_d = rr_idx;
            rr_ptr_d   = (rr_idx == id_width_lp'(num_req_p - 1)) ? '0 : rr_idx + id_width_lp'(1);
        end

        // A second fence while one is outstanding is ignored.
        if (fence_i && !fence_active_q) begin
            fence_active_d = 1'b1;
        end

        case (state_q)
            eReady: begin
                if (accept) begin
                    pkt_v_d = 1'b1;
                    state_d = eHold;
                end else if (fence_active_q) begin
                    state_d = eFence;
                end
            end
            eHold: begin
                if (out_fire && !accept) begin
                    pkt_v_d = 1'b0;
                    state_d = eReady;
                end
            end
            eFence: begin
                if (credits_q == credits_max_lp) begin
                    fence_done_d   = 1'b1;
                    fence_active_d = 1'b0;
                    state_d        = eReady;
                end
            end
            default: begin
                state_d = eReady;
            end
        endcase
    end

    // Scheduler state registers; reset discards any buffered packet.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= eReady;
            pkt_v_q        <= 1'b0;
            pkt_data_q     <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
            credits_q      <= credits_max_lp;
            fence_active_q <= 1'b0;
            fence_done_q   <= 1'b0;
            credit_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pkt_v_q        <= pkt_v_d;
            pkt_data_q     <= pkt_data_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            credits_q      <= credits_d;
            fence_active_q <= fence_active_d;
            fence_done_q   <= fence_done_d;
            credit_err_q   <= credit_err_d;
        end
    end

    assign pkt_v_o      = pkt_v_q;
    assign pkt_data_o   = pkt_data_q;
    assign grant_id_o   = grant_id_q;
    assign credits_o    = credits_q;
    assign fence_done_o = fence_done_q;
    assign credit_err_o = credit_err_q;
    assign state_o      = state_q;

`ifdef BSG_BP_MC_LINK_SCHED_STATS_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q, stall_d;

    // Count link handshakes and credit-starved cycles; both wrap freely.
    always_comb begin
        issued_d = issued_q + 32'(out_fire);
        stall_d  = stall_q + 32'((|req_v_i) && !accept && (credits_q == '0));
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_count_o = issued_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_bsg_bp_mc_link_scheduler.sv
// Self-checking bench for bsg_bp_mc_link_scheduler: directed scenarios plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_bsg_bp_mc_link_scheduler;
    import bsg_bp_mc_link_sched_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int MAX = 4;
    localparam int IW  = 2;
    localparam int CW  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]        req_v_i = '0;
    logic [N-1:0][W-1:0] req_data_i = '0;
    logic [N-1:0]        req_ready_o;
    logic                pkt_v_o;
    logic [W-1:0]        pkt_data_o;
    logic                pkt_ready_i = 1'b0;
    logic [IW-1:0]       grant_id_o;
    logic                credit_return_i = 1'b0;
    logic [CW-1:0]       credits_o;
    logic                fence_i = 1'b0;
    logic                fence_done_o;
    logic                credit_err_o;
    state_e              state_o;
`ifdef BSG_BP_MC_LINK_SCHED_STATS_EN
    logic [31:0]         issued_count_o;
    logic [31:0]         stall_cycles_o;
`endif

    bsg_bp_mc_link_scheduler #(
        .num_req_p         (N),
        .packet_width_p    (W),
        .max_out_credits_p (MAX)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (req_v_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .pkt_v_o         (pkt_v_o),
        .pkt_data_o      (pkt_data_o),
        .pkt_ready_i     (pkt_ready_i),
        .grant_id_o      (grant_id_o),
        .credit_return_i (credit_return_i),
        .credits_o       (credits_o),
        .fence_i         (fence_i),
        .fence_done_o    (fence_done_o),
        .credit_err_o    (credit_err_o),
        .state_o         (state_o)
`ifdef BSG_BP_MC_LINK_SCHED_STATS_EN
        ,
        .issued_count_o  (issued_count_o),
        .stall_cycles_o  (stall_cycles_o)
`endif
    );

    // ---------------- checker ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Link view: a FIFO of at most one packet awaiting the link, a credit
    // pool, a rotating priority start, and a fence that is pending and then
    // draining until every credit is home.
    logic [W+IW-1:0] exp_q[$];
    logic [W+IW-1:0] m_last;
    int              m_credits;
    int              m_ptr;
    bit              m_fence;
    bit              m_draining;
    bit              m_done;
    bit              m_err;
    int              grant_log[$];
    int              done_pulses;

    task automatic model_reset();
        exp_q.delete();
        m_last     = '0;
        m_credits  = MAX;
        m_ptr      = 0;
        m_fence    = 0;
        m_draining = 0;
        m_done     = 0;
        m_err      = 0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [N-1:0] rv, input bit rdy, input bit ret, input bit fen);
        int              win;
        logic [IW-1:0]   cidx;
        logic [IW-1:0]   wi;
        logic [N-1:0]    exp_rdy;
        logic [W+IW-1:0] cur;
        bit              can, was_full, fence_old, next_done;

        @(negedge clk);
        req_v_i = rv;
        for (int i = 0; i < N; i++) req_data_i[i] = $urandom();
        pkt_ready_i     = rdy;
        credit_return_i = ret;
        fence_i         = fen;
        #1;

        was_full = (exp_q.size() > 0);
        can = (!was_full || rdy) && (m_credits > 0) && !m_fence;
        win = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                cidx = IW'((m_ptr + k) % N);
                if (rv[cidx]) begin
                    win = int'(cidx);
                    break;
                end
            end
        end
        exp_rdy = (win >= 0) ? N'(1 << win) : '0;
        cur = was_full ? exp_q[0] : m_last;

        check("req_ready",  64'(req_ready_o),  64'(exp_rdy));
        check("pkt_v",      64'(pkt_v_o),      64'(was_full));
        check("pkt_data",   64'(pkt_data_o),   64'(cur[W-1:0]));
        check("grant_id",   64'(grant_id_o),   64'(cur[W+IW-1:W]));
        check("credits",    64'(credits_o),    64'(m_credits));
        check("fence_done", 64'(fence_done_o), 64'(m_done));
        check("credit_err", 64'(credit_err_o), 64'(m_err));
        if (fence_done_o === 1'b1) done_pulses++;

        // advance the model by one clock
        fence_old = m_fence;
        next_done = m_draining && (m_credits == MAX);
        if (was_full && rdy) m_last = exp_q.pop_front();
        if (win >= 0) begin
            wi = IW'(win);
            exp_q.push_back({wi, req_data_i[wi]});
            m_ptr = (win + 1) % N;
            grant_log.push_back(win);
        end
        if (win >= 0 && !ret)      m_credits--;
        else if (win < 0 && ret) begin
            if (m_credits == MAX) m_err = 1;
            else                  m_credits++;
        end
        if (next_done) begin
            m_fence    = 0;
            m_draining = 0;
        end else if (fence_old && !was_full && !m_draining) begin
            m_draining = 1;
        end
        if (fen && !fence_old) m_fence = 1;
        m_done = next_done;

        @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        req_v_i = '0; pkt_ready_i = 1'b0; credit_return_i = 1'b0; fence_i = 1'b0;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    int sz;

    initial begin
        model_reset();
        done_pulses = 0;

        // Reset state, with every requester asking while reset is held.
        #1 reset_n = 1'b0;
        req_v_i = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  64'(req_ready_o),  64'(0));
        check("rst_pkt_v",      64'(pkt_v_o),      64'(0));
        check("rst_pkt_data",   64'(pkt_data_o),   64'(0));
        check("rst_grant_id",   64'(grant_id_o),   64'(0));
        check("rst_credits",    64'(credits_o),    64'(MAX));
        check("rst_fence_done", 64'(fence_done_o), 64'(0));
        check("rst_credit_err", 64'(credit_err_o), 64'(0));
        release_reset();

        // Requesters 0 and 2 streaming into an always-ready link.
        grant_log.delete();
        repeat (8) step(4'b0101, 1'b1, 1'b1, 1'b0);
        check("rr_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 4; i++) check("rr_order", 64'(grant_log[i]), 64'((i % 2) * 2));
        repeat (2) step(4'b0000, 1'b1, 1'b0, 1'b0);

        // Credit exhaustion, then a single return re-opens one slot.
        sz = grant_log.size();
        repeat (6) step(4'b1111, 1'b1, 1'b0, 1'b0);
        check("exhaust_issued", 64'(grant_log.size()), 64'(sz + MAX));
        check("exhaust_credits", 64'(credits_o), 64'(0));
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        check("return_no_same_cycle", 64'(grant_log.size()), 64'(sz + MAX));
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        check("return_next_cycle", 64'(grant_log.size()), 64'(sz + MAX + 1));
        repeat (MAX) step(4'b0000, 1'b1, 1'b1, 1'b0);

        // Link back-pressure for five cycles while holding a packet.
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (5) step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0);

        // Fence with three outstanding requests, then three returns.
        repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0);
        done_pulses = 0;
        sz = grant_log.size();
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b1);
        repeat (3) step(4'b1111, 1'b1, 1'b1, 1'b0);
        check("fence_blocks", 64'(grant_log.size()), 64'(sz));
        repeat (4) step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("fence_done_once", 64'(done_pulses), 64'(1));

        // Fence coincident with an acceptance lets that one through only.
        sz = grant_log.size();
        step(4'b0100, 1'b1, 1'b0, 1'b1);
        check("fence_coincident", 64'(grant_log.size()), 64'(sz + 1));
        repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0);
        check("fence_coincident_block", 64'(grant_log.size()), 64'(sz + 1));
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] rv;
            bit rdy, ret, fen;
            rv  = N'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 9) < 7);
            ret = (m_credits < MAX) && ($urandom_range(0, 9) < 4);
            fen = ($urandom_range(0, 99) < 3);
            step(rv, rdy, ret, fen);
        end

        // Drain everything before the overflow check.
        for (int c = 0; c < 40 && (m_credits < MAX || m_fence || exp_q.size() > 0); c++)
            step(4'b0000, 1'b1, (m_credits < MAX), 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0, 1'b0);

        // Return into a full pool: dropped, error flag sticks.
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("overflow_credits", 64'(credits_o), 64'(MAX));
        check("overflow_err", 64'(credit_err_o), 64'(1));

        // Reset in the middle of a held packet.
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req_v_i = '1;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_pkt_v",     64'(pkt_v_o),      64'(0));
        check("midrst_credits",   64'(credits_o),    64'(MAX));
        check("midrst_req_ready", 64'(req_ready_o),  64'(0));
        check("midrst_err",       64'(credit_err_o), 64'(0));
        check("midrst_grant_id",  64'(grant_id_o),   64'(0));
        release_reset();
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bsg_bp_mc_link_scheduler.md
BSG_BP_MC_LINK_SCHEDULER -- requirements
Module: bsg_bp_mc_link_scheduler

Interface
REQ-001 SHALL have parameter num_req_p, default 4, number of requesters sharing one manycore request link.
REQ-002 SHALL have parameter packet_width_p, default 128, manycore request packet width in bits.
REQ-003 SHALL have parameter max_out_credits_p, default 16, maximum outstanding (unacknowledged) requests on the link.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock for all logic.
REQ-005 SHALL have port reset_n_i, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port req_v_i, input, num_req_p bits, per-requester valid.
REQ-007 SHALL have port req_data_i, input, num_req_p x packet_width_p, per-requester packet.
REQ-008 SHALL have port req_ready_o, output, num_req_p bits, per-requester accept; at most one bit set per cycle.
REQ-009 SHALL have port pkt_v_o, output, 1 bit, link packet valid.
REQ-010 SHALL have port pkt_data_o, output, packet_width_p, link packet.
REQ-011 SHALL have port pkt_ready_i, input, 1 bit, link accept.
REQ-012 SHALL have port grant_id_o, output, clog2(num_req_p), source of the current pkt_data_o.
REQ-013 SHALL have port credit_return_i, input, 1 bit, one-cycle pulse per returned response.
REQ-014 SHALL have port credits_o, output, clog2(max_out_credits_p+1), available credits.
REQ-015 SHALL have port fence_i, input, 1 bit, pulse requesting a drain.
REQ-016 SHALL have port fence_done_o, output, 1 bit, one-cycle pulse when the drain is complete.
REQ-017 SHALL have port credit_err_o, output, 1 bit, sticky credit-overflow flag.

Function
REQ-018 SHALL implement FSM states eReady, eHold and eFence.
REQ-019 In eReady, or in eHold on a cycle with pkt_v_o & pkt_ready_i, SHALL accept the round-robin winner among req_v_i when credits_o>0 and no fence is pending, via a combinational req_ready_o.
REQ-020 An accepted packet SHALL be registered into the output buffer, making pkt_v_o high the following cycle (1-cycle latency), and the FSM SHALL enter or remain in eHold.
REQ-021 In eHold, pkt_v_o SHALL stay high, with pkt_data_o and grant_id_o stable, until pkt_ready_i.
REQ-022 If the output handshake completes with no new acceptance, the FSM SHALL return to eReady.
REQ-023 Round-robin priority SHALL start at (last winner + 1) mod num_req_p; after reset requester 0 SHALL have the highest priority.
REQ-024 Credits SHALL decrement on acceptance and increment on credit_return_i; a simultaneous decrement and return SHALL leave credits_o unchanged.
REQ-025 A credit_return_i arriving when credits_o==max_out_credits_p, with no simultaneous decrement, SHALL be dropped and SHALL set credit_err_o until reset.
REQ-026 With credits_o==0, SHALL NOT accept any request; already-buffered packets SHALL still drain.
REQ-027 A fence_i pulse SHALL block new acceptances from the next cycle onward; the FSM SHALL enter eFence once the output buffer is empty.
REQ-028 In eFence, when credits_o==max_out_credits_p, SHALL pulse fence_done_o for exactly one cycle and go to eReady.
REQ-029 fence_i while a fence is already pending or in eFence SHALL be ignored.
REQ-030 fence_i coincident with an acceptance SHALL allow that acceptance; the fence SHALL block from the next cycle.

Reset
REQ-031 On reset_n_i low, asynchronously: state eReady, pkt_v_o=0, pkt_data_o=0, grant_id_o=0, credits_o=max_out_credits_p, fence_done_o=0, credit_err_o=0, RR pointer at requester 0, req_ready_o=0 while reset is asserted.
REQ-032 Reset asserted mid-packet SHALL discard the buffered packet; there SHALL be no replay.

Configuration
REQ-033 With BSG_BP_MC_LINK_SCHED_STATS_EN defined, SHALL add 32-bit outputs issued_count_o (output handshakes) and stall_cycles_o (cycles with any req_v_i, no acceptance and credits_o==0), both wrapping at 2^32 and reset to 0.
REQ-034 Without BSG_BP_MC_LINK_SCHED_STATS_EN, those ports and their counters SHALL NOT exist.

Structure
REQ-035 The FSM state enum and the default parameter constants SHALL reside in bsg_bp_mc_link_sched_pkg.
REQ-036 Round-robin selection SHALL be a sub-module bsg_bp_mc_rr_select taking num_req_p requests and the pointer, and returning a one-hot grant and an index.

Verification
REQ-037 Requesters 0 and 2 held valid, pkt_ready_i=1 -> grant order 0,2,0,2, one packet per cycle after the first.
REQ-038 max_out_credits_p=2, no returns, 3 requests -> exactly 2 issued, credits_o=0, third accepted 1 cycle after a credit_return_i pulse.
REQ-039 pkt_ready_i low for 5 cycles during eHold -> pkt_data_o and grant_id_o unchanged and req_ready_o=0 throughout.
REQ-040 fence_i with 3 outstanding, then 3 returns -> no acceptances, fence_done_o pulses once in the cycle after credits_o reaches max.
REQ-041 credit_return_i at full credits -> credits_o stays max, credit_err_o=1 until reset.
REQ-042 reset_n_i asserted while pkt_v_o=1 -> pkt_v_o=0 immediately, credits_o=max.
